mux_serializer: RTL and testbench

MUX_SERIALIZER -- requirements
Module: mux_serializer

---
 rtl/mux_ser_pkg.sv | 9 +
 rtl/mux_grp_sel.sv | 16 +
 rtl/mux_serializer.sv | 98 +++++++++
 tb/tb_mux_serializer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux_ser_pkg.sv
// Shared types for the mux serializer: FSM state encoding.
package mux_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/mux_grp_sel.sv
// Selects the B-bit group at index sel from a (2**N)*B-bit word by shifting right sel*B bits.
module mux_grp_sel #(
  parameter int N = 2,
  parameter int B = 2
) (
  input  logic [(2**N)*B-1:0] word,
  input  logic [N-1:0]        sel,
  output logic [B-1:0]        grp
);

  logic [31:0] shamt;

  assign shamt = 32'(sel) * 32'(B);
  assign grp   = B'(word >> shamt);

endmodule

// File: rtl/mux_serializer.sv
// Serializes a (2**N)*B-bit word into B-bit groups; first beat one cycle after accept, beats hold while out_ready=0.
// Define MUX_SER_MSB_FIRST_EN to emit groups from index 2**N-1 down to 0 instead of 0 upward.
module mux_serializer
  import mux_ser_pkg::*;
#(
  parameter int N = 2,
  parameter int B = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [(2**N)*B-1:0] X,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [B-1:0]        Y,
  output logic [N-1:0]        A,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                last
);

  localparam int W        = (2**N)*B;
  localparam int LAST_IDX = 2**N - 1;

`ifdef MUX_SER_MSB_FIRST_EN
  localparam logic [N-1:0] START_IDX = N'(LAST_IDX);
  localparam logic [N-1:0] END_IDX   = '0;
`else
  localparam logic [N-1:0] START_IDX = '0;
  localparam logic [N-1:0] END_IDX   = N'(LAST_IDX);
`endif

  ser_state_e     state_q, state_d;
  logic [W-1:0]   word_q, word_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   next_idx;

`ifdef MUX_SER_MSB_FIRST_EN
  assign next_idx = a_q - 1'b1;
`else
  assign next_idx = a_q + 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      a_q     <= a_d;
    end
  end

  // The last beat returns to IDLE without stepping A, so the index never wraps.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    a_d       = a_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = X;
          a_d     = START_IDX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        last      = (a_q == END_IDX);
        if (out_ready) begin
          if (a_q == END_IDX) begin
            state_d = IDLE;
          end else begin
            a_d = next_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign A = a_q;

  mux_grp_sel #(
    .N (N),
    .B (B)
  ) u_grp_sel (
    .word (word_q),
    .sel  (a_q),
    .grp  (Y)
  );

endmodule

// File: tb/tb_mux_serializer.sv
// Directed self-checking bench for mux_serializer (N=2/B=2 and N=4/B=1 instances), either group order.
module tb_mux_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] x;
  logic       in_valid, in_ready;
  logic [1:0] y, a;
  logic       out_valid, out_ready, last;

  logic [15:0] wx;
  logic        w_in_valid, w_in_ready, wy;
  logic [3:0]  wa;
  logic        w_out_valid, w_out_ready, w_last;

  mux_serializer #(.N(2), .B(2)) dut (
    .clk(clk), .rst(rst), .X(x), .in_valid(in_valid), .in_ready(in_ready),
    .Y(y), .A(a), .out_valid(out_valid), .out_ready(out_ready), .last(last)
  );

  mux_serializer #(.N(4), .B(1)) dut_w (
    .clk(clk), .rst(rst), .X(wx), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .Y(wy), .A(wa), .out_valid(w_out_valid), .out_ready(w_out_ready), .last(w_last)
  );

`ifdef MUX_SER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Groups of 8'hB4 and 8'h1B, indexed by A.
  logic [1:0] grp_b4 [4];
  logic [1:0] grp_1b [4];

  function automatic int idx_of(input int k, input int last_idx);
    return MSB ? (last_idx - k) : k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic beat(input string tag, input int k, input logic [1:0] ey);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_A"},         32'(a),         32'(idx_of(k, 3)));
    chk({tag, "_Y"},         32'(y),         32'(ey));
    chk({tag, "_last"},      32'(last),      32'(k == 3));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"},      32'(last),      32'd0);
  endtask

  initial begin
    grp_b4 = '{2'b00, 2'b01, 2'b11, 2'b10};
    grp_1b = '{2'b11, 2'b10, 2'b01, 2'b00};

    rst = 1'b1; x = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    wx = 16'h0000; w_in_valid = 1'b0; w_out_ready = 1'b1;

    // Reset dominates a valid input word.
    #17;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_A",         32'(a),         32'd0);
    chk("rst_Y",         32'(y),         32'd0);
    chk("rst_last",      32'(last),      32'd0);
    chk("rst_w_valid",   32'(w_out_valid), 32'd0);
    chk("rst_w_A",       32'(wa),        32'd0);

    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    idle_chk("post_rst");

    // Basic word, consumer always ready.
    x = 8'hB4; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      beat("seq", k, grp_b4[idx_of(k, 3)]);
    end
    @(negedge clk);
    idle_chk("seq_idle");

    // Three stall cycles on the second beat.
    x = 8'hB4; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      beat("stall", k, grp_b4[idx_of(k, 3)]);
      if (k == 1) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          beat("stall_hold", 1, grp_b4[idx_of(1, 3)]);
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    idle_chk("stall_idle");

    // X and in_valid toggled during SHIFT are ignored.
    x = 8'hB4; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      beat("ignore", k, grp_b4[idx_of(k, 3)]);
      x = 8'hFF;
      in_valid = (k < 3);
    end
    @(negedge clk);
    idle_chk("ignore_idle");

    // Reset in the middle of a word.
    x = 8'hB4; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      beat("pre_rst", k, grp_b4[idx_of(k, 3)]);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_A",         32'(a),         32'd0);
    chk("mid_rst_Y",         32'(y),         32'd0);
    chk("mid_rst_last",      32'(last),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_chk("mid_rst_release");
    @(negedge clk);
    idle_chk("mid_rst_no_beat");

    x = 8'h1B; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      beat("after_rst", k, grp_1b[idx_of(k, 3)]);
    end
    @(negedge clk);
    idle_chk("after_rst_idle");

    // Wide instance: N=4, B=1, back-to-back words, 17 cycles per word.
    wx = 16'h8001; w_in_valid = 1'b1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if ((c % 17) < 16) begin
        chk("wide_out_valid", 32'(w_out_valid), 32'd1);
        chk("wide_A",    32'(wa),     32'(idx_of(c % 17, 15)));
        chk("wide_Y",    32'(wy),     32'((idx_of(c % 17, 15) == 0) || (idx_of(c % 17, 15) == 15)));
        chk("wide_last", 32'(w_last), 32'((c % 17) == 15));
      end else begin
        chk("wide_gap_out_valid", 32'(w_out_valid), 32'd0);
        chk("wide_gap_in_ready",  32'(w_in_ready),  32'd1);
      end
    end
    w_in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
